// File: rtl/clock24_counter_if.sv
// clock24_counter_if: button inputs and time/status outputs of the 24-hour clock core
interface clock24_counter_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] edit_field;
    logic       sec_pulse;
    logic       day_wrap;
    modport master (output mode_btn, inc_btn, input hours, minutes, seconds, edit_field, sec_pulse, day_wrap);
    modport slave (input mode_btn, inc_btn, output hours, minutes, seconds, edit_field, sec_pulse, day_wrap);
endinterface

// File: rtl/clock24_counter.sv
// clock24_counter: 1 Hz prescaler, hh:mm:ss registers and button-driven hour/minute set mode
module clock24_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W = 26
) (
    input logic clk,
    input logic resetn,
    clock24_counter_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    state_t state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic sec_pulse_q, sec_pulse_d;
    logic day_wrap_q, day_wrap_d;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] arm_q, arm_d;
    logic [1:0] press_q, press_d;
    logic [1:0] settle_q, settle_d;
    logic tick, mode_press, inc_press, sec_max, min_max, hour_max;
    // Bit 0 is the mode button, bit 1 the inc button. A button is armed only once it has
    // been seen released after reset, so a press held through reset never fires.
    always_comb begin
        sync1_d = {bus.inc_btn, bus.mode_btn};
        sync2_d = sync1_q;
        prev_d = sync2_q;
        settle_d = {settle_q[0], 1'b1};
        arm_d = arm_q | ({2{settle_q[1]}} & ~sync2_q);
        press_d = sync2_q & ~prev_q & arm_q;
    end
    assign mode_press = press_q[0];
    assign inc_press = press_q[1] & ~press_q[0];
    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign sec_max = seconds_q == 6'd59;
    assign min_max = minutes_q == 6'd59;
    assign hour_max = hours_q == 5'd23;
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        seconds_d = tick ? (sec_max ? '0 : seconds_q + 6'd1) : seconds_q;
        minutes_d = (tick && sec_max) ? (min_max ? '0 : minutes_q + 6'd1) : minutes_q;
        hours_d = (tick && sec_max && min_max) ? (hour_max ? '0 : hours_q + 5'd1) : hours_q;
        sec_pulse_d = tick;
        day_wrap_d = tick && sec_max && min_max && hour_max;
        case (state_q)
            RUN: begin
                presc_d = (mode_press || tick) ? '0 : presc_q + 1'b1;
                state_d = mode_press ? SET_HOUR : RUN;
            end
            SET_HOUR: begin
                state_d = mode_press ? SET_MIN : SET_HOUR;
                hours_d = inc_press ? (hour_max ? '0 : hours_q + 5'd1) : hours_q;
            end
            SET_MIN: begin
                state_d = mode_press ? RUN : SET_MIN;
                seconds_d = mode_press ? '0 : seconds_q;
                minutes_d = inc_press ? (min_max ? '0 : minutes_q + 6'd1) : minutes_q;
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            presc_q <= '0;
            hours_q <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            sec_pulse_q <= 1'b0;
            day_wrap_q <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q <= '0;
            arm_q <= '0;
            press_q <= '0;
            settle_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hours_q <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q <= day_wrap_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q <= prev_d;
            arm_q <= arm_d;
            press_q <= press_d;
            settle_q <= settle_d;
        end
    end
    assign bus.hours = hours_q;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.edit_field = state_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap = day_wrap_q;
endmodule

// File: tb/tb_clock24_counter.sv
// tb_clock24_counter: scoreboard bench for clock24_counter with TICKS_PER_SEC = 4
module tb_clock24_counter;
    localparam int TICKS = 4;
    typedef struct {
        int h;
        int m;
        int s;
        logic w;
    } exp_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last = -1;
    int prev_edit = 0;
    int npulse = 0;
    int nwrap = 0;
    int mh = 0;
    int mm = 0;
    int ms = 0;
    exp_t sb[$];
    clock24_counter_if bus();
    clock24_counter #(.TICKS_PER_SEC(TICKS), .PRESC_W(3)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );
    always #10 clk = ~clk;
    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask
    task automatic push_sec(input int n);
        exp_t x;
        repeat (n) begin
            x.w = (mh == 23 && mm == 59 && ms == 59);
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    mh++;
                    if (mh == 24) mh = 0;
                end
            end
            x.h = mh;
            x.m = mm;
            x.s = ms;
            sb.push_back(x);
        end
    endtask
    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            chk("h_rng", int'(bus.hours <= 5'd23), 1);
            chk("m_rng", int'(bus.minutes <= 6'd59), 1);
            chk("s_rng", int'(bus.seconds <= 6'd59), 1);
            if (bus.sec_pulse) begin
                npulse++;
                if (bus.day_wrap) nwrap++;
                if (last >= 0) chk("gap", cyc - last, TICKS);
                last = cyc;
                if (sb.size() == 0) chk("extra_pulse", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("p_h", int'(bus.hours), e.h);
                    chk("p_m", int'(bus.minutes), e.m);
                    chk("p_s", int'(bus.seconds), e.s);
                    chk("p_wrap", int'(bus.day_wrap), int'(e.w));
                end
            end else chk("wrap_alone", int'(bus.day_wrap), 0);
            if (bus.edit_field != 2'd0) last = -1;
            else if (prev_edit != 0) last = cyc;
            prev_edit = int'(bus.edit_field);
        end
    endtask
    task automatic press(input logic m, input logic i, input int hold, input int rel);
        bus.mode_btn = m;
        bus.inc_btn = i;
        step(hold);
        bus.mode_btn = 1'b0;
        bus.inc_btn = 1'b0;
        step(rel);
    endtask
    task automatic incs(input int n);
        repeat (n) press(1'b0, 1'b1, 5, 5);
    endtask
    task automatic chk_time(input string tag, input int h, input int m, input int s, input int ef);
        chk({tag, "_h"}, int'(bus.hours), h);
        chk({tag, "_m"}, int'(bus.minutes), m);
        chk({tag, "_s"}, int'(bus.seconds), s);
        chk({tag, "_ef"}, int'(bus.edit_field), ef);
    endtask
    initial begin
        bus.mode_btn = 1'b0;
        bus.inc_btn = 1'b0;
        step(3);
        chk_time("rst", 0, 0, 0, 0);
        chk("rst_pulse", int'(bus.sec_pulse), 0);
        resetn = 1'b1;
        last = cyc;
        push_sec(10);
        step(40);
        chk_time("run40", 0, 0, 10, 0);
        chk("run40_pulses", npulse, 10);
        push_sec(1);
        press(1'b1, 1'b0, 5, 5);
        chk_time("set_h_entry", 0, 0, 11, 1);
        step(100);
        chk_time("frozen", 0, 0, 11, 1);
        incs(25);
        chk_time("hour25", 1, 0, 11, 1);
        press(1'b1, 1'b1, 5, 5);
        chk_time("mode_inc", 1, 0, 11, 2);
        incs(30);
        chk_time("min30", 1, 30, 11, 2);
        incs(61);
        chk_time("min61", 1, 31, 11, 2);
        press(1'b0, 1'b1, 50, 5);
        chk_time("inc_hold", 1, 32, 11, 2);
        mh = 1;
        mm = 32;
        ms = 0;
        push_sec(3);
        press(1'b1, 1'b0, 5, 5);
        press(1'b0, 1'b1, 5, 1);
        chk_time("run_inc", 1, 32, 3, 0);
        push_sec(1);
        press(1'b1, 1'b0, 5, 5);
        chk_time("tick_mode", 1, 32, 4, 1);
        incs(22);
        press(1'b1, 1'b0, 5, 5);
        incs(27);
        chk_time("set2359", 23, 59, 4, 2);
        mh = 23;
        mm = 59;
        ms = 0;
        push_sec(60);
        press(1'b1, 1'b0, 5, 5);
        step(234);
        chk_time("rollover", 0, 0, 0, 0);
        chk("wrap_count", nwrap, 1);
        push_sec(55);
        step(220);
        push_sec(1);
        press(1'b1, 1'b0, 5, 5);
        incs(12);
        press(1'b1, 1'b0, 5, 5);
        incs(34);
        chk_time("pre_rst", 12, 34, 56, 2);
        bus.mode_btn = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk_time("async_rst", 0, 0, 0, 0);
        chk("async_pulse", int'(bus.sec_pulse), 0);
        #2 resetn = 1'b1;
        mh = 0;
        mm = 0;
        ms = 0;
        push_sec(5);
        step(21);
        chk_time("held_mode", 0, 0, 5, 0);
        bus.mode_btn = 1'b0;
        push_sec(2);
        step(8);
        chk_time("after_rel", 0, 0, 7, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock24_counter.md
Name: clock24_counter

Overview:
Time-keeping core of the 24-hour digital clock. It divides the board clock into a 1 Hz tick and maintains binary hours, minutes and seconds registers. It also provides a button-driven set mode for hours and minutes. Outputs feed Clock24DispDecoder directly, using the same widths: hours 5 bits, minutes 6 bits, seconds 6 bits.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; benches use 4.
PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
resetn  input  1  asynchronous active-low reset.
mode_btn  input  1  level button, asynchronous to clk; a press cycles the mode.
inc_btn  input  1  level button, asynchronous to clk; a press increments the field being edited.
hours  output  5  0..23, binary.
minutes  output  6  0..59, binary.
seconds  output  6  0..59, binary.
edit_field  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; used by the display to blink the edited field.
sec_pulse  output  1  one-cycle strobe on every seconds increment in RUN.
day_wrap  output  1  one-cycle strobe when 23:59:59 rolls over to 00:00:00.

Behaviour:
- Reset (resetn low, asynchronous): hours = 0, minutes = 0, seconds = 0, state = RUN, edit_field = 0, prescaler = 0, sec_pulse = 0, day_wrap = 0, synchronizer and edge flops = 0. Outputs stay at these values while resetn is held low.
- Button input path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector (sync2 high and previous-sample flop low).
  - The result is a one-cycle press strobe asserted on the 3rd clk edge that samples the button high.
  - The register update takes effect on the edge following the strobe.
  - Holding a button high produces exactly one press. Nothing auto-repeats.
- Prescaler:
  - In RUN it counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - tick = 1 in the cycle where prescaler == TICKS_PER_SEC-1.
  - In SET_HOUR and SET_MIN the prescaler is held at 0.
- RUN on tick:
  - seconds += 1 and sec_pulse = 1 in the following cycle, aligned with the new seconds value.
  - seconds 59 -> 0 carries into minutes. Minutes 59 -> 0 carries into hours. Hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in one edge, with day_wrap = 1 in the same cycle as sec_pulse.
  - Intermediate out-of-range values never appear on the outputs.
- State machine, advanced by the mode press: RUN -> SET_HOUR -> SET_MIN -> RUN. edit_field follows the state.
  - Entering SET_HOUR: seconds are frozen and the prescaler is cleared.
  - SET_MIN -> RUN: seconds are cleared to 0 and the prescaler restarts from 0. The first tick therefore arrives TICKS_PER_SEC cycles after the transition edge.
- Increment in SET states:
  - In SET_HOUR an inc press does hours = (hours == 23) ? 0 : hours + 1. There is no carry and minutes are untouched.
  - In SET_MIN an inc press does minutes = (minutes == 59) ? 0 : minutes + 1. There is no carry into hours.
  - In RUN the inc press is ignored.
- Simultaneous events:
  - Mode press and inc press in the same cycle: mode wins and inc is dropped.
  - A mode press in the same cycle as a RUN tick: the tick is applied first (the time advances), then the state becomes SET_HOUR.
  - No sec_pulse or day_wrap is generated outside RUN.
- Reset mid-operation, in any state or mid-press: immediate return to reset values. A button still held after resetn rises does not generate a press until it is released and pressed again.

Test Plan (TICKS_PER_SEC = 4):
- Reset and run: release resetn and run 40 clk cycles -> seconds = 10, minutes = 0, hours = 0. Exactly 10 sec_pulse strobes, spaced 4 cycles apart.
- Rollover: use set mode to reach 23:59, return to RUN (seconds = 0), then run 60 ticks -> 00:00:00 in one edge. day_wrap is a single-cycle strobe coincident with sec_pulse; no intermediate value such as 24 or 60 is observed.
- Set hours: mode press -> edit_field = 1, seconds frozen for 100 cycles. 25 inc presses starting from 0 -> hours = 1 (wraps at 23), minutes unchanged.
- Set minutes and exit: from SET_HOUR, mode -> edit_field = 2. 61 inc presses starting from 30 -> minutes = 31, hours unchanged. Mode -> RUN with seconds = 0; the first sec_pulse comes 4 cycles after the transition.
- Button hygiene: hold inc high for 50 cycles in SET_MIN -> minutes +1 only. Mode and inc presses in the same cycle from SET_HOUR -> SET_MIN, hours unchanged. inc press in RUN -> no change.
- Async reset: at 12:34:56 in SET_MIN, pulse resetn low for 3 ns between clk edges -> all outputs 0 and edit_field = 0 immediately, without waiting for a clk edge. With mode_btn held high across the reset, no mode change occurs.
